// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule.
// Takes the last round key K10 and walks the expansion backwards, one round per
// accepted key. Round keys are streamed in the order K10 down to K0 over a
// valid/ready handshake, which is the order the decryption rounds use them.
module aes_inv_key_schedule #(
  parameter int          NUM_ROUNDS = 10,
  parameter logic [7:0]  RCON_LAST  = 8'h36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_last,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Forward AES S-box; SBOX[x] is the substitution of byte x.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Four parallel S-box lookups, one per byte of the word.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Undo one xtime step: multiply by x^-1 in GF(2^8).
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    if (r[0]) begin
      inv_xtime = ((r ^ 8'h1b) >> 1) | 8'h80;
    end else begin
      inv_xtime = r >> 1;
    end
  endfunction

  // One backward round: rebuild the previous round key from the current one.
  // Words 1..3 only need an XOR of neighbours; word 0 needs the recovered
  // word 3 rotated, substituted and combined with the round constant.
  function automatic logic [127:0] inv_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rc, 24'h000000};
    inv_round = {p0, p1, p2, p3};
  endfunction

  state_t        state_r, state_nx;
  logic [127:0]  key_r,   key_nx;
  logic [3:0]    idx_r,   idx_nx;
  logic [7:0]    rcon_r,  rcon_nx;
  logic          valid_r, valid_nx;
  logic          busy_r,  busy_nx;
  logic          done_r,  done_nx;

  // Next-state and next-datapath decode; everything holds unless a load or an accepted key moves it.
  always_comb begin
    state_nx = state_r;
    key_nx   = key_r;
    idx_nx   = idx_r;
    rcon_nx  = rcon_r;
    valid_nx = valid_r;
    busy_nx  = busy_r;
    done_nx  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          key_nx   = key_last;
          idx_nx   = 4'(NUM_ROUNDS);
          rcon_nx  = RCON_LAST;
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          state_nx = EMIT;
        end else begin
          state_nx = IDLE;
        end
      end
      EMIT: begin
        if (valid_r && rk_ready) begin
          if (idx_r == 4'd0) begin
            // K0 consumed: round_key/round_idx keep the K0 values.
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            key_nx  = inv_round(key_r, rcon_r);
            rcon_nx = inv_xtime(rcon_r);
            idx_nx  = idx_r - 4'd1;
          end
        end else begin
          state_nx = EMIT;
        end
      end
      default: begin
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      key_r   <= 128'h0;
      idx_r   <= 4'd0;
      rcon_r  <= RCON_LAST;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      key_r   <= key_nx;
      idx_r   <= idx_nx;
      rcon_r  <= rcon_nx;
      valid_r <= valid_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
    end
  end

  assign round_key = key_r;
  assign round_idx = idx_r;
  assign rk_valid  = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule.
// The reference derives the S-box from GF(2^8) inversion plus the affine map,
// and recovers round keys by inverting the FIPS-197 word recurrence over a
// 44-word array. A per-cycle compare process tracks the handshake stream.
module tb_aes_inv_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_last;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;
  logic rr_en = 1'b0;
  logic [7:0] sb [256];

  aes_inv_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_last  (key_last),
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
  endfunction

  // Invert w[i+4] = w[i] ^ temp going from word 43 down to word 0.
  function automatic logic [10:0][127:0] expand(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [7:0]  rc [11];
    logic [10:0][127:0] ks;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc[i] = gmul(rc[i-1], 8'h02);
    w[40] = k10[127:96]; w[41] = k10[95:64]; w[42] = k10[63:32]; w[43] = k10[31:0];
    for (int i = 39; i >= 0; i--) begin
      if (((i + 4) % 4) == 0)
        w[i] = w[i+4] ^ subrot(w[i+3]) ^ {rc[(i+4)/4], 24'h000000};
      else
        w[i] = w[i+4] ^ w[i+3];
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // Ready driver: random about half the time when enabled, otherwise tied high.
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rr_en) rk_ready = 1'($urandom & 32'd1);
      else rk_ready = 1'b1;
    end
  end

  // Reference stream: compare every cycle, then advance on what the next edge will do.
  logic [10:0][127:0] m_ks;
  logic [127:0] m_key = 128'h0;
  int  m_idx = 0;
  logic m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_key = 128'h0; m_idx = 0;
      end
      chk("rk_valid", 128'(rk_valid), 128'(m_valid));
      chk("busy", 128'(busy), 128'(m_busy));
      chk("done", 128'(done), 128'(m_done));
      chk("round_idx", 128'(round_idx), 128'(m_idx));
      chk("round_key", round_key, m_key);
      if (rst_n) begin
        m_done = 1'b0;
        if (m_valid) begin
          if (rk_ready) begin
            if (m_idx == 0) begin
              m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            end else begin
              m_idx = m_idx - 1;
              m_key = m_ks[m_idx];
            end
          end
        end else if (start) begin
          m_ks = expand(key_last);
          m_idx = 10;
          m_key = m_ks[10];
          m_valid = 1'b1;
          m_busy = 1'b1;
        end
      end
    end
  end

  task automatic do_start(input logic [127:0] k);
    start = 1'b1;
    key_last = k;
    @(posedge clk);
    #1;
    start = 1'b0;
    key_last = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("done_timeout", 128'(done), 128'd1);
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    while (int'(round_idx) != target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idx", 128'(round_idx), 128'(target));
  endtask

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [10:0][127:0] pk;
  int n;

  // Main stimulus sequence.
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key_last = 128'h0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    chk("pin_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("pin_sbox_53", 128'(sb[8'h53]), 128'hed);
    pk = expand(128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("pin_c1_k10", pk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("pin_c1_k9", pk[9], 128'h549932d1f08557681093ed9cbe2c974e);
    chk("pin_c1_k1", pk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("pin_c1_k0", pk[0], 128'h000102030405060708090a0b0c0d0e0f);
    pk = expand(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin_a1_k0", pk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1 with ready tied high; done must land 12 cycles after start.
    do_start(128'h13111d7fe3944a17f307a78b4d2b30c5);
    wait_done(n);
    chk("c1_done_latency", 128'(n), 128'd12);
    chk("c1_final_key", round_key, 128'h000102030405060708090a0b0c0d0e0f);
    @(posedge clk); #1;

    // FIPS-197 A.1.
    do_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_done(n);
    chk("a1_final_key", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(posedge clk); #1;

    // Random keys under random backpressure.
    rr_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      do_start({$urandom, $urandom, $urandom, $urandom});
      wait_done(n);
      repeat (2) @(posedge clk);
      #1;
    end
    rr_en = 1'b0;
    @(posedge clk); #1;

    // A second start mid-run is ignored.
    do_start({$urandom, $urandom, $urandom, $urandom});
    wait_idx(5);
    start = 1'b1;
    key_last = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    @(posedge clk); #1;

    // Reset mid-run aborts with no done pulse; a fresh run then completes.
    rr_en = 1'b1;
    do_start({$urandom, $urandom, $urandom, $urandom});
    wait_idx(3);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_key", round_key, 128'h0);
    chk("rst_idx", 128'(round_idx), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_no_done", 128'(done), 128'd0);
    end
    do_start(128'h13111d7fe3944a17f307a78b4d2b30c5);
    wait_done(n);
    chk("post_rst_k0", round_key, 128'h000102030405060708090a0b0c0d0e0f);
    rr_en = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: start in the done cycle gives K10 of the new key next cycle.
    do_start({$urandom, $urandom, $urandom, $urandom});
    wait_done(n);
    do_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("b2b_idx", 128'(round_idx), 128'd10);
    chk("b2b_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("b2b_valid", 128'(rk_valid), 128'd1);
    wait_done(n);
    chk("b2b_k0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
